sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single-port Memory_Unit SRAM between two requesters: the RISC_SPM
//  processor port (cpu_*) and an external loader/debug port (ext_*). Same-cycle
//  req/gnt handshake, round-robin on contention, optional lock for bursts with a
//  bounded hold. Sits between Processing_Unit/Control_Unit and Memory_Unit.
// PARAMETERS
//  WORD_SIZE  8  data width of both ports and SRAM
//  ADDR_SIZE  8  address width of both ports and SRAM
//  MAX_HOLD   4  max consecutive locked grants before forced handover (>=1)
// PORTS
//  clk        in   1          system clock; all state updates on rising edge
//  rst        in   1          one clock; reset is asynchronous and active-low
//  cpu_req    in   1          CPU access request; held until cpu_gnt
//  cpu_we     in   1          1=write, 0=read
//  cpu_lock   in   1          request to keep ownership for next access
//  cpu_addr   in   ADDR_SIZE  access address
//  cpu_wdata  in   WORD_SIZE  write data
//  cpu_gnt    out  1          access issued this cycle (combinational)
//  cpu_rvalid out  1          read data valid (cycle after read gnt)
//  cpu_rdata  out  WORD_SIZE  read data; 0 when cpu_rvalid=0
//  ext_*      --   --         identical set: ext_req/we/lock/addr/wdata/gnt/rvalid/rdata
//  mem_addr   out  ADDR_SIZE  to SRAM address; winner's addr, 0 when idle
//  mem_wdata  out  WORD_SIZE  to SRAM data_in; winner's wdata, 0 when idle
//  mem_write  out  1          to SRAM write; = gnt & we of winner
//  mem_rdata  in   WORD_SIZE  from SRAM data_out; valid 1 cycle after address
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, last_winner=EXT (CPU wins first tie),
//    hold_cnt=0, both rvalid=0; all gnt/mem_* combinationally 0 while in reset.
//  - FSM: IDLE, CPU_OWN, EXT_OWN. State = owner after the current grant;
//    IDLE when no grant issued this cycle. At most one gnt per cycle.
//  - Winner, per cycle: none req -> no gnt. One req -> it wins. Both req:
//    owner wins if owner lock=1 and hold_cnt<MAX_HOLD-1; else requester !=
//    last_winner wins. Lock ignored if other side not requesting (owner keeps).
//  - hold_cnt: +1 per consecutive locked grant to same owner; 0 on owner change,
//    on IDLE, or on grant with lock=0. Forced handover clears it.
//  - Handshake: gnt asserts in the cycle the access hits SRAM; requester may
//    change fields next cycle. Write commits at that edge. Throughput 1/cycle.
//  - Read: rvalid registered = prev-cycle gnt & !we; rdata = mem_rdata gated.
//    Latency gnt->rvalid = 1 cycle; back-to-back reads give back-to-back rvalid.
//  - Reset mid-access: pending rvalid dropped, no write beyond current edge.
//  - Requester dropping req without gnt: legal, no side effects.
// CONFIGURATION
//  SRAM_ARB_STATS_EN defined: adds outputs cpu_gnt_cnt[15:0], ext_gnt_cnt[15:0],
//  conflict_cnt[15:0] (cycles both req), saturating at 16'hFFFF, reset to 0,
//  plus input stats_clr (sync clear, takes priority over increment).
//  Not defined: these ports and counters do not exist; arbitration identical.
// STRUCTURE
//  - Shared package risc_spm_pkg: FSM state encodings (ST_IDLE/ST_CPU/ST_EXT),
//    requester IDs (REQ_CPU=0, REQ_EXT=1), STAT_W=16.
//  - One sub-module: sram_arb_stats (counter bank), instantiated only under
//    SRAM_ARB_STATS_EN. Winner logic, FSM, rvalid pipe stay in top.
// TESTING
//  1 Reset: rst=0 with both req=1 -> no gnt, mem_write=0, rvalid=0; release ->
//    CPU gets first gnt.
//  2 CPU write 8'h3C@8'h10, then read @8'h10 -> cpu_gnt each cycle, cpu_rvalid
//    next cycle with cpu_rdata=8'h3C, ext_rvalid=0.
//  3 Both req, lock=0, 6 cycles -> gnt alternates CPU,EXT,CPU,EXT,CPU,EXT.
//  4 CPU lock=1, both req, MAX_HOLD=4 -> CPU gets 4 grants, then EXT 1 grant,
//    then CPU again.
//  5 Reset asserted cycle after ext read gnt -> ext_rvalid stays 0 after release.
//  6 STATS_EN: 20 contended cycles -> conflict_cnt=20, cpu+ext gnt_cnt=20;
//    stats_clr -> all 0; preload near max -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC_SPM memory-side blocks.
//  - arb_state_e : ownership FSM states of the SRAM port arbiter
//  - req_id_e    : requester identifiers used for round-robin bookkeeping
//  - STAT_W      : width of the optional statistics counters
//  - sat_inc     : saturating increment helper for the statistics counters
package risc_spm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CPU  = 2'b01,
        ST_EXT  = 2'b10
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_EXT = 1'b1
    } req_id_e;

    localparam int STAT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        if (v == {STAT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(STAT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_arb_stats.sv
// Statistics counter bank for sram_port_arbiter (only instantiated when
// SRAM_ARB_STATS_EN is defined).
// Ports:
//  clk, rst          clock, asynchronous active-low reset
//  stats_clr         synchronous clear, wins over any increment
//  cpu_gnt, ext_gnt  grant strobes from the arbiter
//  conflict          both requesters asserting req this cycle
//  cpu_gnt_cnt, ext_gnt_cnt, conflict_cnt   saturating counters
module sram_arb_stats
    import risc_spm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stats_clr,
    input  logic              cpu_gnt,
    input  logic              ext_gnt,
    input  logic              conflict,
    output logic [STAT_W-1:0] cpu_gnt_cnt,
    output logic [STAT_W-1:0] ext_gnt_cnt,
    output logic [STAT_W-1:0] conflict_cnt
);

    logic [STAT_W-1:0] cpu_cnt_r;
    logic [STAT_W-1:0] ext_cnt_r;
    logic [STAT_W-1:0] conf_cnt_r;

    // Counter registers: clear has priority, increments saturate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_cnt_r  <= {STAT_W{1'b0}};
            ext_cnt_r  <= {STAT_W{1'b0}};
            conf_cnt_r <= {STAT_W{1'b0}};
        end else if (stats_clr) begin
            cpu_cnt_r  <= {STAT_W{1'b0}};
            ext_cnt_r  <= {STAT_W{1'b0}};
            conf_cnt_r <= {STAT_W{1'b0}};
        end else begin
            if (cpu_gnt) begin
                cpu_cnt_r <= sat_inc(cpu_cnt_r);
            end
            if (ext_gnt) begin
                ext_cnt_r <= sat_inc(ext_cnt_r);
            end
            if (conflict) begin
                conf_cnt_r <= sat_inc(conf_cnt_r);
            end
        end
    end

    assign cpu_gnt_cnt  = cpu_cnt_r;
    assign ext_gnt_cnt  = ext_cnt_r;
    assign conflict_cnt = conf_cnt_r;

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of the single-port Memory_Unit SRAM.
// The RISC_SPM processor (cpu_*) and an external loader/debug port (ext_*)
// share the SRAM with a same-cycle req/gnt handshake, round-robin on
// contention and an optional lock that keeps ownership for at most MAX_HOLD
// consecutive grants while the other side is waiting.
// Ports:
//  clk, rst                      clock, asynchronous active-low reset
//  {cpu,ext}_req/we/lock         request, write enable, ownership lock
//  {cpu,ext}_addr/wdata          access address and write data
//  {cpu,ext}_gnt                 access issued this cycle (combinational)
//  {cpu,ext}_rvalid/rdata        read return one cycle after a read grant
//  mem_addr/wdata/write          SRAM drive, zero when no grant
//  mem_rdata                     SRAM read data (one cycle after address)
// Configuration macro: SRAM_ARB_STATS_EN adds stats_clr and the
// cpu_gnt_cnt/ext_gnt_cnt/conflict_cnt counters.
module sram_port_arbiter
    import risc_spm_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MAX_HOLD  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic                 cpu_lock,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    input  logic                 ext_req,
    input  logic                 ext_we,
    input  logic                 ext_lock,
    input  logic [ADDR_SIZE-1:0] ext_addr,
    input  logic [WORD_SIZE-1:0] ext_wdata,
    output logic                 ext_gnt,
    output logic                 ext_rvalid,
    output logic [WORD_SIZE-1:0] ext_rdata,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_rdata
`ifdef SRAM_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [STAT_W-1:0]    cpu_gnt_cnt,
    output logic [STAT_W-1:0]    ext_gnt_cnt,
    output logic [STAT_W-1:0]    conflict_cnt
`endif
);

    // Extra headroom bit keeps the counter width >= 2 even for MAX_HOLD=1.
    localparam int HOLD_W = $clog2(MAX_HOLD + 1) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    arb_state_e         state_r;
    arb_state_e         next_s;
    req_id_e            last_r;
    req_id_e            last_nxt_s;
    logic [HOLD_W-1:0]  hold_r;
    logic [HOLD_W-1:0]  hold_nxt_s;
    logic               cpu_win_s;
    logic               ext_win_s;
    logic               cpu_rvalid_r;
    logic               ext_rvalid_r;

    // Winner selection. The owner may keep the port under contention only
    // while locked and below the hold bound; otherwise round-robin decides.
    // Everything is forced idle while reset is asserted.
    always_comb begin
        cpu_win_s = 1'b0;
        ext_win_s = 1'b0;
        if (!rst) begin
            cpu_win_s = 1'b0;
            ext_win_s = 1'b0;
        end else if (cpu_req && ext_req) begin
            if ((state_r == ST_CPU) && cpu_lock && (hold_r < HOLD_LIM)) begin
                cpu_win_s = 1'b1;
            end else if ((state_r == ST_EXT) && ext_lock && (hold_r < HOLD_LIM)) begin
                ext_win_s = 1'b1;
            end else if (last_r == REQ_EXT) begin
                cpu_win_s = 1'b1;
            end else begin
                ext_win_s = 1'b1;
            end
        end else if (cpu_req) begin
            cpu_win_s = 1'b1;
        end else if (ext_req) begin
            ext_win_s = 1'b1;
        end else begin
            cpu_win_s = 1'b0;
            ext_win_s = 1'b0;
        end
    end

    // Next owner, round-robin pointer and hold counter. The hold counter
    // only advances on a locked grant to the side that already owns the
    // port; it saturates at the bound so an uncontended lock cannot wrap.
    always_comb begin
        next_s     = ST_IDLE;
        last_nxt_s = last_r;
        hold_nxt_s = {HOLD_W{1'b0}};
        if (cpu_win_s) begin
            next_s     = ST_CPU;
            last_nxt_s = REQ_CPU;
            if ((state_r == ST_CPU) && cpu_lock) begin
                hold_nxt_s = (hold_r < HOLD_LIM) ? hold_r + HOLD_ONE : hold_r;
            end else begin
                hold_nxt_s = {HOLD_W{1'b0}};
            end
        end else if (ext_win_s) begin
            next_s     = ST_EXT;
            last_nxt_s = REQ_EXT;
            if ((state_r == ST_EXT) && ext_lock) begin
                hold_nxt_s = (hold_r < HOLD_LIM) ? hold_r + HOLD_ONE : hold_r;
            end else begin
                hold_nxt_s = {HOLD_W{1'b0}};
            end
        end else begin
            next_s     = ST_IDLE;
            hold_nxt_s = {HOLD_W{1'b0}};
        end
    end

    // Ownership state, round-robin pointer and hold counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            last_r  <= REQ_EXT;
            hold_r  <= {HOLD_W{1'b0}};
        end else begin
            state_r <= next_s;
            last_r  <= last_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    // SRAM drive: the winner's fields, zero when nobody is granted.
    always_comb begin
        mem_addr  = {ADDR_SIZE{1'b0}};
        mem_wdata = {WORD_SIZE{1'b0}};
        mem_write = 1'b0;
        case ({cpu_win_s, ext_win_s})
            2'b10: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_write = cpu_we;
            end
            2'b01: begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                mem_write = ext_we;
            end
            default: begin
                mem_addr  = {ADDR_SIZE{1'b0}};
                mem_wdata = {WORD_SIZE{1'b0}};
                mem_write = 1'b0;
            end
        endcase
    end

    // Read-return pipe: a read granted this cycle returns data next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid_r <= 1'b0;
            ext_rvalid_r <= 1'b0;
        end else begin
            cpu_rvalid_r <= cpu_win_s & ~cpu_we;
            ext_rvalid_r <= ext_win_s & ~ext_we;
        end
    end

    assign cpu_gnt    = cpu_win_s;
    assign ext_gnt    = ext_win_s;
    assign cpu_rvalid = cpu_rvalid_r;
    assign ext_rvalid = ext_rvalid_r;
    assign cpu_rdata  = cpu_rvalid_r ? mem_rdata : {WORD_SIZE{1'b0}};
    assign ext_rdata  = ext_rvalid_r ? mem_rdata : {WORD_SIZE{1'b0}};

`ifdef SRAM_ARB_STATS_EN
    sram_arb_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .stats_clr    (stats_clr),
        .cpu_gnt      (cpu_win_s),
        .ext_gnt      (ext_win_s),
        .conflict     (cpu_req & ext_req),
        .cpu_gnt_cnt  (cpu_gnt_cnt),
        .ext_gnt_cnt  (ext_gnt_cnt),
        .conflict_cnt (conflict_cnt)
    );
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter with a behavioural
// reference model (owner / last-winner / hold bookkeeping plus a shadow
// memory) and a simple synchronous SRAM attached to the mem_* port.
module tb_sram_port_arbiter;
    import risc_spm_pkg::*;

    localparam int WS = 8;
    localparam int AS = 8;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_lock;
    logic [AS-1:0] cpu_addr;
    logic [WS-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [WS-1:0] cpu_rdata;
    logic          ext_req, ext_we, ext_lock;
    logic [AS-1:0] ext_addr;
    logic [WS-1:0] ext_wdata;
    logic          ext_gnt, ext_rvalid;
    logic [WS-1:0] ext_rdata;
    logic [AS-1:0] mem_addr;
    logic [WS-1:0] mem_wdata;
    logic          mem_write;
    logic [WS-1:0] mem_rdata = 8'h00;
`ifdef SRAM_ARB_STATS_EN
    logic          stats_clr;
    logic [15:0]   cpu_gnt_cnt, ext_gnt_cnt, conflict_cnt;
`endif

    always #5 clk = ~clk;

    sram_port_arbiter #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
`ifdef SRAM_ARB_STATS_EN
        , .stats_clr(stats_clr), .cpu_gnt_cnt(cpu_gnt_cnt),
        .ext_gnt_cnt(ext_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    // Synchronous single-port SRAM: read returns the pre-write contents.
    logic [WS-1:0] sram [256] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_write) sram[mem_addr] <= mem_wdata;
        mem_rdata <= sram[mem_addr];
    end

    // Reference model state
    int            m_owner;   // -1 none, 0 cpu, 1 ext
    int            m_last;
    int            m_hold;
    bit            m_rv [2];
    logic [WS-1:0] m_rd [2];
    logic [WS-1:0] m_mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_hold  = 0;
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        m_rd[0] = '0;
        m_rd[1] = '0;
    endtask

    function automatic int pick_winner();
        if (rst !== 1'b1) return -1;
        if (cpu_req && ext_req) begin
            if (m_owner == 0 && cpu_lock && m_hold < MH - 1) return 0;
            if (m_owner == 1 && ext_lock && m_hold < MH - 1) return 1;
            return 1 - m_last;
        end
        if (cpu_req) return 0;
        if (ext_req) return 1;
        return -1;
    endfunction

    // One clock cycle with inputs already applied: check, clock, update model.
    task automatic tick(output logic [1:0] g, output logic cv, output logic [WS-1:0] crd,
                        output logic ev);
        int            w;
        logic [AS-1:0] ea;
        logic [WS-1:0] ed;
        logic          ewr;
        bit            locked;
        #2;
        if (rst !== 1'b1) model_reset();
        w   = pick_winner();
        ea  = (w == 0) ? cpu_addr  : (w == 1) ? ext_addr  : 8'h00;
        ed  = (w == 0) ? cpu_wdata : (w == 1) ? ext_wdata : 8'h00;
        ewr = (w == 0) ? cpu_we    : (w == 1) ? ext_we    : 1'b0;
        g   = {cpu_gnt, ext_gnt};
        cv  = cpu_rvalid;
        crd = cpu_rdata;
        ev  = ext_rvalid;
        chk("cpu_gnt",    32'(cpu_gnt),    32'(w == 0));
        chk("ext_gnt",    32'(ext_gnt),    32'(w == 1));
        chk("mem_addr",   32'(mem_addr),   32'(ea));
        chk("mem_wdata",  32'(mem_wdata),  32'(ed));
        chk("mem_write",  32'(mem_write),  32'(ewr));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rv[0]));
        chk("cpu_rdata",  32'(cpu_rdata),  m_rv[0] ? 32'(m_rd[0]) : 32'h0);
        chk("ext_rvalid", 32'(ext_rvalid), 32'(m_rv[1]));
        chk("ext_rdata",  32'(ext_rdata),  m_rv[1] ? 32'(m_rd[1]) : 32'h0);
        @(posedge clk);
        m_rv[0] = (w == 0) && !cpu_we;
        m_rv[1] = (w == 1) && !ext_we;
        m_rd[0] = m_mem[cpu_addr];
        m_rd[1] = m_mem[ext_addr];
        if (w >= 0 && ewr) m_mem[ea] = ed;
        locked = (w == 0) ? cpu_lock : (w == 1) ? ext_lock : 1'b0;
        if (w >= 0 && w == m_owner && locked) m_hold = (m_hold + 1 > MH - 1) ? MH - 1 : m_hold + 1;
        else m_hold = 0;
        m_owner = w;
        if (w >= 0) m_last = w;
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic lock,
                           input logic [AS-1:0] a, input logic [WS-1:0] d);
        cpu_req = req; cpu_we = we; cpu_lock = lock; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ext(input logic req, input logic we, input logic lock,
                           input logic [AS-1:0] a, input logic [WS-1:0] d);
        ext_req = req; ext_we = we; ext_lock = lock; ext_addr = a; ext_wdata = d;
    endtask

    task automatic do_reset();
        logic [1:0] g; logic cv; logic [WS-1:0] crd; logic ev;
        set_cpu(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_ext(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        tick(g, cv, crd, ev);
        rst = 1'b1;
    endtask

    initial begin
        logic [1:0]    g;
        logic          cv, ev;
        logic [WS-1:0] crd;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        model_reset();
`ifdef SRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        // 1: reset with both requesting -> nothing issued; release -> CPU first
        rst = 1'b0;
        set_cpu(1'b1, 1'b1, 1'b0, 8'h20, 8'hAA);
        set_ext(1'b1, 1'b1, 1'b0, 8'h21, 8'h55);
        tick(g, cv, crd, ev);
        chk("t1_rst_gnt", 32'(g), 32'h0);
        chk("t1_rst_rv", 32'({cv, ev}), 32'h0);
        rst = 1'b1;
        set_cpu(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        set_ext(1'b1, 1'b0, 1'b0, 8'h21, 8'h00);
        tick(g, cv, crd, ev);
        chk("t1_first_cpu", 32'(g), 32'h2);

        // 2: CPU write 3C@10 then read @10
        do_reset();
        set_cpu(1'b1, 1'b1, 1'b0, 8'h10, 8'h3C);
        tick(g, cv, crd, ev);
        chk("t2_wr_gnt", 32'(g), 32'h2);
        set_cpu(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        tick(g, cv, crd, ev);
        chk("t2_rd_gnt", 32'(g), 32'h2);
        set_cpu(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick(g, cv, crd, ev);
        chk("t2_rvalid", 32'(cv), 32'h1);
        chk("t2_rdata", 32'(crd), 32'h3C);
        chk("t2_ext_rv", 32'(ev), 32'h0);

        // 3: contention without lock alternates starting with CPU
        do_reset();
        set_cpu(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
        set_ext(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
        for (int i = 0; i < 6; i++) begin
            tick(g, cv, crd, ev);
            chk("t3_alt", 32'(g), (i % 2 == 0) ? 32'h2 : 32'h1);
        end

        // 4: locked CPU holds for MAX_HOLD grants, then one EXT grant
        do_reset();
        set_cpu(1'b1, 1'b1, 1'b1, 8'h03, 8'h11);
        set_ext(1'b1, 1'b1, 1'b0, 8'h04, 8'h22);
        for (int i = 0; i < 6; i++) begin
            tick(g, cv, crd, ev);
            chk("t4_hold", 32'(g), (i == 4) ? 32'h1 : 32'h2);
        end

        // 5: reset right after an EXT read grant drops the pending rvalid
        do_reset();
        set_ext(1'b1, 1'b0, 1'b0, 8'h04, 8'h00);
        tick(g, cv, crd, ev);
        chk("t5_ext_gnt", 32'(g), 32'h1);
        set_ext(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        tick(g, cv, crd, ev);
        chk("t5_rv_in_rst", 32'(ev), 32'h0);
        rst = 1'b1;
        tick(g, cv, crd, ev);
        chk("t5_rv_after", 32'(ev), 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            set_cpu(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                    8'($urandom_range(0, 15)), 8'($urandom));
            set_ext(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                    8'($urandom_range(0, 15)), 8'($urandom));
            tick(g, cv, crd, ev);
        end
        rst = 1'b1;

`ifdef SRAM_ARB_STATS_EN
        // 6: statistics counters
        do_reset();
        stats_clr = 1'b1;
        tick(g, cv, crd, ev);
        stats_clr = 1'b0;
        set_cpu(1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
        set_ext(1'b1, 1'b0, 1'b0, 8'h06, 8'h00);
        for (int i = 0; i < 20; i++) tick(g, cv, crd, ev);
        chk("t6_conflict", 32'(conflict_cnt), 32'd20);
        chk("t6_gnt_sum", 32'(cpu_gnt_cnt) + 32'(ext_gnt_cnt), 32'd20);
        set_cpu(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_ext(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        stats_clr = 1'b1;
        tick(g, cv, crd, ev);
        stats_clr = 1'b0;
        chk("t6_clr", 32'({cpu_gnt_cnt, ext_gnt_cnt}) | 32'(conflict_cnt), 32'h0);
        set_cpu(1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
        set_ext(1'b1, 1'b0, 1'b0, 8'h06, 8'h00);
        repeat (65540) @(posedge clk);
        #1;
        chk("t6_sat", 32'(conflict_cnt), 32'hFFFF);
        chk("t6_cpu_cnt", 32'(cpu_gnt_cnt), 32'd32770);
        chk("t6_ext_cnt", 32'(ext_gnt_cnt), 32'd32770);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
